// File: rtl/key_event_arbiter.sv
// key_event_arbiter: latches debounced key presses as pending events and offers them one at
// a time, round-robin from a moving pointer, over valid/ready with an idle gap after each event.
module key_event_arbiter #(
  parameter int N_KEYS  = 4,
  parameter int ID_W    = 2,
  parameter int GAP_CYC = 16,
  parameter int GAP_W   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_flag,
  input  logic [N_KEYS-1:0] key_value,
  input  logic              en,
  input  logic              flush,
  input  logic              clr_drop,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [ID_W-1:0]   evt_id,
  output logic [N_KEYS-1:0] pend,
  output logic              drop,
  output logic              busy
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_OFFER = 2'd1;
  localparam logic [1:0]       ST_GAP   = 2'd2;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_KEYS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);

  logic [1:0]        state_q, state_d;
  logic [N_KEYS-1:0] pend_q, pend_d;
  logic              drop_q, drop_d;
  logic              valid_q, valid_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [GAP_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic [N_KEYS-1:0] press_s;
  logic [N_KEYS-1:0] grant_s;
  logic [ID_W-1:0]   sel_s;
  logic              grant_en_s;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_KEYS) begin
      sum = sum - N_KEYS;
    end else begin
      sum = sum;
    end
    return sum[ID_W-1:0];
  endfunction

  assign press_s = key_flag & ~key_value;

  // Round-robin select: scanning downwards lets the key nearest the pointer win.
  always_comb begin
    sel_s = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      sel_s = pend_q[wrap_add(ptr_q, k)] ? wrap_add(ptr_q, k) : sel_s;
    end
  end

  // Grant strobe: only from IDLE, so a grant never coincides with a live offer.
  always_comb begin
    grant_en_s = (state_q == ST_IDLE) && en && (|pend_q);
    if (grant_en_s) begin
      grant_s = {{(N_KEYS-1){1'b0}}, 1'b1} << sel_s;
    end else begin
      grant_s = '0;
    end
  end

  // Capture: a new press beats both the grant clear and flush; re-press of a pending key is a drop.
  always_comb begin
    pend_d = (pend_q & ~grant_s & ~{N_KEYS{flush}}) | press_s;
    drop_d = (|(press_s & pend_q & ~grant_s)) | (drop_q & ~clr_drop);
  end

  // Offer/gap sequencing.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_en_s) begin
          state_d = ST_OFFER;
          valid_d = 1'b1;
          id_d    = sel_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          ptr_d   = (id_q == LAST_ID) ? {ID_W{1'b0}} : id_q + ID_W'(1);
          if (GAP_LOAD == {GAP_W{1'b0}}) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          state_d = ST_OFFER;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q - GAP_W'(1);
        if (cnt_q <= GAP_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_OFFER) || (state_d == ST_GAP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign pend      = pend_q;
  assign drop      = drop_q;
  assign busy      = busy_q;

endmodule
